// File: rtl/regfile_mp_sb_pkg.sv
// regfile_pkg: shared defaults, types and helpers for the multi-port register file
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;
    localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

    typedef logic [AW_DEFAULT-1:0]   reg_addr_t;
    typedef logic [XLEN_DEFAULT-1:0] xlen_t;

    // True when the address names the hardwired zero register
    function automatic logic is_zero_reg(input int unsigned addr, input logic zero_reg);
        return zero_reg && (addr == 0);
    endfunction

endpackage

// File: rtl/regfile_mp_sb_if.sv
// regfile_mp_sb_if: read, write and reservation bus between issue logic and the register file
interface regfile_mp_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2,
    parameter int NWR   = 1
);
    localparam int AW = $clog2(NREGS);

    logic [NRD-1:0][AW-1:0]   rd_addr;
    logic [NRD-1:0][XLEN-1:0] rd_data;
    logic [NRD-1:0]           rd_busy;
    logic [NWR-1:0]           wr_en;
    logic [NWR-1:0][AW-1:0]   wr_addr;
    logic [NWR-1:0][XLEN-1:0] wr_data;
    logic                     rsv_en;
    logic [AW-1:0]            rsv_addr;
    logic [AW:0]              busy_cnt;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        input  rd_data, rd_busy, busy_cnt
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
        output rd_data, rd_busy, busy_cnt
    );
endinterface

// File: rtl/regfile_mp_sb_scoreboard.sv
// regfile_scoreboard: per-register pending bits and their population counter
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int NREGS    = NREGS_DEFAULT,
    parameter  int NWR      = 1,
    parameter  int ZERO_REG = 1,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NWR-1:0]         i_wr_en,
    input  logic [NWR-1:0][AW-1:0] i_wr_addr,
    input  logic                   i_rsv_en,
    input  logic [AW-1:0]          i_rsv_addr,
    output logic [NREGS-1:0]       o_busy,
    output logic [AW:0]            o_busy_cnt
);

    logic [NREGS-1:0] r_busy, w_set, w_clr, w_next;
    logic [AW:0]      r_cnt, w_inc, w_dec, w_pop;

    // Writebacks clear, a reservation sets; set applied last so the new producer wins
    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int j = 0; j < NWR; j++)
            if (i_wr_en[j] && !is_zero_reg(32'(i_wr_addr[j]), ZERO_REG != 0)) w_clr[i_wr_addr[j]] = 1'b1;
        if (i_rsv_en && !is_zero_reg(32'(i_rsv_addr), ZERO_REG != 0)) w_set[i_rsv_addr] = 1'b1;
        w_next = (r_busy & ~w_clr) | w_set;
        w_inc  = '0;
        w_dec  = '0;
        for (int k = 0; k < NREGS; k++) begin
            w_inc = w_inc + (AW+1)'(w_next[k] & ~r_busy[k]);
            w_dec = w_dec + (AW+1)'(r_busy[k] & ~w_next[k]);
        end
    end

    // Reference population count used only to cross-check the incremental counter
    always_comb begin
        w_pop = '0;
        for (int k = 0; k < NREGS; k++) w_pop = w_pop + (AW+1)'(r_busy[k]);
    end

    // Busy bits and counter advance together so the count always matches the bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
            r_cnt  <= '0;
        end else begin
            r_busy <= w_next;
            r_cnt  <= r_cnt + w_inc - w_dec;
        end
    end

    a_cnt_matches: assert property (@(posedge clk) disable iff (rst) r_cnt == w_pop);

    assign o_busy     = r_busy;
    assign o_busy_cnt = r_cnt;

endmodule

// File: rtl/regfile_mp_sb.sv
// regfile_mp_sb: multi-port register file with write bypass and pending-write scoreboard
module regfile_mp_sb
    import regfile_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NREGS    = NREGS_DEFAULT,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input logic            clk,
    input logic            rst,
    regfile_mp_sb_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0]  r_regs [NREGS];
    logic [NREGS-1:0] w_busy;

    regfile_scoreboard #(
        .NREGS    (NREGS),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (bus.wr_en),
        .i_wr_addr  (bus.wr_addr),
        .i_rsv_en   (bus.rsv_en),
        .i_rsv_addr (bus.rsv_addr),
        .o_busy     (w_busy),
        .o_busy_cnt (bus.busy_cnt)
    );

    // Commit enabled writes; a later port overrides an earlier one on the same address
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
        end else begin
            for (int j = 0; j < NWR; j++)
                if (bus.wr_en[j] && !is_zero_reg(32'(bus.wr_addr[j]), ZERO_REG != 0)) r_regs[bus.wr_addr[j]] <= bus.wr_data[j];
        end
    end

    // Zero-latency reads with forwarding; a forwarded value is no longer pending unless re-reserved
    always_comb begin : rd_mux
        logic w_byp;
        logic w_hit;
        bus.rd_data = '0;
        bus.rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            w_byp          = 1'b0;
            bus.rd_data[i] = r_regs[bus.rd_addr[i]];
            for (int j = 0; j < NWR; j++)
                if (BYPASS != 0 && bus.wr_en[j] && bus.wr_addr[j] == bus.rd_addr[i] &&
                    !is_zero_reg(32'(bus.wr_addr[j]), ZERO_REG != 0)) begin
                    bus.rd_data[i] = bus.wr_data[j];
                    w_byp          = 1'b1;
                end
            w_hit          = bus.rsv_en && bus.rsv_addr == bus.rd_addr[i];
            bus.rd_busy[i] = w_busy[bus.rd_addr[i]] && !(w_byp && !w_hit);
            if (is_zero_reg(32'(bus.rd_addr[i]), ZERO_REG != 0)) begin
                bus.rd_data[i] = '0;
                bus.rd_busy[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// tb_regfile_mp_sb: directed vector bench for the multi-port register file and scoreboard
module tb_regfile_mp_sb;

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0, wa1;
        logic [31:0] wd0, wd1;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic        b0, b1;
        logic [5:0]  cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs [15];

    always #5 clk = ~clk;

    regfile_mp_sb_if #(.NWR(2)) m ();
    regfile_mp_sb_if            c ();

    regfile_mp_sb #(.NWR(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    regfile_mp_sb #(.ZERO_REG(0), .BYPASS(0)) dut_c (
        .clk (clk),
        .rst (rst),
        .bus (c)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m.wr_en = '0; m.wr_addr = '0; m.wr_data = '0; m.rsv_en = 1'b0; m.rsv_addr = '0; m.rd_addr = '0;
        c.wr_en = '0; c.wr_addr = '0; c.wr_data = '0; c.rsv_en = 1'b0; c.rsv_addr = '0; c.rd_addr = '0;
    endtask

    task automatic check_all_clear(input string tag);
        for (int a = 0; a < 32; a++) begin
            m.rd_addr[0] = 5'(a);
            m.rd_addr[1] = 5'(31 - a);
            #1;
            chk($sformatf("%s d0 a%0d", tag, a), m.rd_data[0], 32'h0);
            chk($sformatf("%s d1 a%0d", tag, a), m.rd_data[1], 32'h0);
            chk($sformatf("%s b0 a%0d", tag, a), 32'(m.rd_busy[0]), 32'h0);
            chk($sformatf("%s b1 a%0d", tag, a), 32'(m.rd_busy[1]), 32'h0);
        end
        chk($sformatf("%s cnt", tag), 32'(m.busy_cnt), 32'h0);
    endtask

    initial begin
        vecs[0]  = '{2'b01, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vecs[1]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vecs[2]  = '{2'b01, 5'd7, 5'd0, 32'h12345678, 32'h0,        1'b0, 5'd0, 5'd7, 5'd6, 32'h12345678, 32'h0,        1'b0, 1'b0, 6'd0};
        vecs[3]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd7, 5'd0, 32'h12345678, 32'h0,        1'b0, 1'b0, 6'd0};
        vecs[4]  = '{2'b11, 5'd9, 5'd9, 32'hAAAA0000, 32'h5555FFFF, 1'b0, 5'd0, 5'd9, 5'd7, 32'h5555FFFF, 32'h12345678, 1'b0, 1'b0, 6'd0};
        vecs[5]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h5555FFFF, 32'h5555FFFF, 1'b0, 1'b0, 6'd0};
        vecs[6]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd3, 5'd3, 5'd4, 32'h0,        32'h0,        1'b0, 1'b0, 6'd0};
        vecs[7]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd4, 5'd3, 5'd4, 32'h0,        32'h0,        1'b1, 1'b0, 6'd1};
        vecs[8]  = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b1, 5'd3, 5'd3, 5'd4, 32'h0,        32'h0,        1'b1, 1'b1, 6'd2};
        vecs[9]  = '{2'b01, 5'd3, 5'd0, 32'hCAFEF00D, 32'h0,        1'b1, 5'd3, 5'd3, 5'd4, 32'hCAFEF00D, 32'h0,        1'b1, 1'b1, 6'd2};
        vecs[10] = '{2'b01, 5'd4, 5'd0, 32'h0BADC0DE, 32'h0,        1'b0, 5'd0, 5'd3, 5'd4, 32'hCAFEF00D, 32'h0BADC0DE, 1'b1, 1'b0, 6'd2};
        vecs[11] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd3, 5'd4, 32'hCAFEF00D, 32'h0BADC0DE, 1'b1, 1'b0, 6'd1};
        vecs[12] = '{2'b10, 5'd0, 5'd3, 32'h0,        32'h11112222, 1'b0, 5'd0, 5'd3, 5'd5, 32'h11112222, 32'h0,        1'b0, 1'b0, 6'd1};
        vecs[13] = '{2'b01, 5'd5, 5'd0, 32'h00000001, 32'h0,        1'b1, 5'd6, 5'd3, 5'd6, 32'h11112222, 32'h0,        1'b0, 1'b0, 6'd0};
        vecs[14] = '{2'b00, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 5'd0, 5'd5, 5'd6, 32'h00000001, 32'h0,        1'b0, 1'b1, 6'd1};

        idle();
        rst = 1'b1;
        m.wr_en[0] = 1'b1; m.wr_addr[0] = 5'd5; m.wr_data[0] = 32'hDEADBEEF;
        m.rsv_en = 1'b1; m.rsv_addr = 5'd5;
        tick();
        tick();
        rst = 1'b0;
        idle();
        check_all_clear("reset");

        c.wr_en[0] = 1'b1; c.wr_addr[0] = 5'd0; c.wr_data[0] = 32'hFFFFFFFF;
        c.rsv_en = 1'b1; c.rsv_addr = 5'd0; c.rd_addr[0] = 5'd0;
        #1;
        chk("nz x0 pre", c.rd_data[0], 32'h0);
        tick();
        idle();
        #1;
        chk("nz x0 data", c.rd_data[0], 32'hFFFFFFFF);
        chk("nz x0 busy", 32'(c.rd_busy[0]), 32'h1);
        chk("nz cnt1", 32'(c.busy_cnt), 32'd1);
        c.wr_en[0] = 1'b1; c.wr_addr[0] = 5'd7; c.wr_data[0] = 32'h12345678; c.rd_addr[0] = 5'd7;
        #1;
        chk("nobyp x7 pre", c.rd_data[0], 32'h0);
        tick();
        idle();
        c.rd_addr[0] = 5'd7;
        #1;
        chk("nobyp x7 post", c.rd_data[0], 32'h12345678);
        c.rsv_en = 1'b1; c.rsv_addr = 5'd2;
        tick();
        idle();
        c.wr_en[0] = 1'b1; c.wr_addr[0] = 5'd2; c.wr_data[0] = 32'h5; c.rd_addr[0] = 5'd2;
        #1;
        chk("nobyp x2 data pre", c.rd_data[0], 32'h0);
        chk("nobyp x2 busy pre", 32'(c.rd_busy[0]), 32'h1);
        chk("nobyp cnt2", 32'(c.busy_cnt), 32'd2);
        tick();
        idle();
        c.rd_addr[0] = 5'd2;
        #1;
        chk("nobyp x2 data post", c.rd_data[0], 32'h5);
        chk("nobyp x2 busy post", 32'(c.rd_busy[0]), 32'h0);
        chk("nobyp cnt post", 32'(c.busy_cnt), 32'd1);

        for (int i = 0; i < 15; i++) begin
            m.wr_en = vecs[i].we;
            m.wr_addr[0] = vecs[i].wa0; m.wr_addr[1] = vecs[i].wa1;
            m.wr_data[0] = vecs[i].wd0; m.wr_data[1] = vecs[i].wd1;
            m.rsv_en = vecs[i].re; m.rsv_addr = vecs[i].ra;
            m.rd_addr[0] = vecs[i].a0; m.rd_addr[1] = vecs[i].a1;
            #1;
            chk($sformatf("vec%0d d0", i), m.rd_data[0], vecs[i].d0);
            chk($sformatf("vec%0d d1", i), m.rd_data[1], vecs[i].d1);
            chk($sformatf("vec%0d b0", i), 32'(m.rd_busy[0]), 32'(vecs[i].b0));
            chk($sformatf("vec%0d b1", i), 32'(m.rd_busy[1]), 32'(vecs[i].b1));
            chk($sformatf("vec%0d cnt", i), 32'(m.busy_cnt), 32'(vecs[i].cnt));
            tick();
        end
        idle();

        for (int k = 0; k < 11; k++) begin
            m.rsv_en = 1'b1; m.rsv_addr = 5'(10 + k);
            #1;
            chk($sformatf("rsv%0d cnt", 10 + k), 32'(m.busy_cnt), 32'(1 + k));
            tick();
        end
        idle();
        m.rd_addr[0] = 5'd15; m.rd_addr[1] = 5'd7;
        #1;
        chk("rsv all cnt", 32'(m.busy_cnt), 32'd12);
        chk("rsv x15 busy", 32'(m.rd_busy[0]), 32'h1);
        chk("x7 kept", m.rd_data[1], 32'h12345678);
        rst = 1'b1;
        m.rsv_en = 1'b1; m.rsv_addr = 5'd12;
        m.wr_en[0] = 1'b1; m.wr_addr[0] = 5'd13; m.wr_data[0] = 32'h77777777;
        tick();
        rst = 1'b0;
        idle();
        check_all_clear("midrst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
